// File: rtl/flicker_field_blinker_if.sv
// Bus between the segment encoder / button logic and flicker_field_blinker.
// The master drives the flicker toggle, button pulses and encoded digits;
// the slave (the blinker) returns the blanked digits and the edit state.
interface flicker_field_blinker_if;
    logic        ClkFlick;
    logic        btn_mode;
    logic        btn_adj;
    logic [41:0] seg_in;
    logic [41:0] seg_out;
    logic [1:0]  field;
    logic        editing;

    modport master (
        output ClkFlick,
        output btn_mode,
        output btn_adj,
        output seg_in,
        input  seg_out,
        input  field,
        input  editing
    );

    modport slave (
        input  ClkFlick,
        input  btn_mode,
        input  btn_adj,
        input  seg_in,
        output seg_out,
        output field,
        output editing
    );
endinterface

// File: rtl/flicker_field_blinker.sv
// flicker_field_blinker: turns each ClkFlick edge into a tick, runs the
// RUN -> HR -> MIN -> SEC clock-setting mode machine and blanks the digits
// of the field being edited during the off half of the blink period.
// Optional feature: define AUTO_TIMEOUT_EN to return to RUN after
// TIMEOUT_TICKS ticks in edit without any button press.
module flicker_field_blinker #(
    parameter int         PHASE_TICKS   = 5,
    parameter int         HOLD_TICKS    = 10,
    parameter int         TIMEOUT_TICKS = 100,
    parameter logic [6:0] SEG_OFF       = 7'h7F
) (
    input  logic                   clk,
    input  logic                   reset,
    flicker_field_blinker_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN = 2'd0,
        ST_HR  = 2'd1,
        ST_MIN = 2'd2,
        ST_SEC = 2'd3
    } field_t;

    localparam int PH_W   = $clog2(PHASE_TICKS + 1);
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    localparam logic [PH_W-1:0]   PH_ZERO   = PH_W'(0);
    localparam logic [PH_W-1:0]   PH_ONE    = PH_W'(1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(PHASE_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);

    // Replace both digits of the selected field with the blank pattern.
    function automatic logic [41:0] blank_field(input logic [41:0] seg,
                                                input logic [1:0]  fld);
        logic [41:0] v;
        v = seg;
        case (fld)
            2'd1:    v[41:28] = {SEG_OFF, SEG_OFF};
            2'd2:    v[27:14] = {SEG_OFF, SEG_OFF};
            2'd3:    v[13:0]  = {SEG_OFF, SEG_OFF};
            default: v        = seg;
        endcase
        return v;
    endfunction

    logic              r_flick_q;
    field_t            r_field;
    logic [PH_W-1:0]   r_phase_cnt;
    logic              r_blink_on;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [41:0]       r_seg_out;
    logic              r_editing;

    logic              w_tick;
    logic              w_edit;
    logic              w_timeout;
    field_t            w_field_nxt;
    logic              w_field_chg;
    logic              w_blank;
    logic              w_editing_nxt;
    logic [41:0]       w_seg_nxt;

    assign w_tick = bus.ClkFlick ^ r_flick_q;
    assign w_edit = (r_field != ST_RUN);

`ifdef AUTO_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [IDLE_W-1:0] IDLE_ZERO = IDLE_W'(0);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_TICKS - 1);

    logic [IDLE_W-1:0] r_idle_cnt;

    // The terminal idle tick leaves edit; any button in that cycle wins.
    assign w_timeout = w_edit && w_tick && !bus.btn_adj &&
                       (r_idle_cnt == IDLE_LAST);

    // Idle tick counter: restarts on any field change or adjust press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idle_cnt <= IDLE_ZERO;
        end else if (w_field_chg || !w_edit || bus.btn_adj) begin
            r_idle_cnt <= IDLE_ZERO;
        end else if (w_tick && (r_idle_cnt != IDLE_LAST)) begin
            r_idle_cnt <= r_idle_cnt + IDLE_ONE;
        end else begin
            r_idle_cnt <= r_idle_cnt;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Delayed copy of ClkFlick; both edges of the toggle produce a tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flick_q <= 1'b0;
        end else begin
            r_flick_q <= bus.ClkFlick;
        end
    end

    // Mode state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_field <= ST_RUN;
        end else begin
            r_field <= w_field_nxt;
        end
    end

    // Next field: btn_mode advances, timeout (if enabled) falls back to RUN.
    always_comb begin
        w_field_nxt = r_field;
        w_field_chg = 1'b0;
        if (bus.btn_mode) begin
            w_field_chg = 1'b1;
            case (r_field)
                ST_RUN:  w_field_nxt = ST_HR;
                ST_HR:   w_field_nxt = ST_MIN;
                ST_MIN:  w_field_nxt = ST_SEC;
                ST_SEC:  w_field_nxt = ST_RUN;
                default: w_field_nxt = ST_RUN;
            endcase
        end else if (w_timeout) begin
            w_field_nxt = ST_RUN;
            w_field_chg = 1'b1;
        end else begin
            w_field_nxt = r_field;
            w_field_chg = 1'b0;
        end
    end

    // Blink phase and adjust hold. While the hold is running the phase stays
    // parked at the start of a visible half, so blinking resumes visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase_cnt <= PH_ZERO;
            r_blink_on  <= 1'b1;
            r_hold_cnt  <= HOLD_ZERO;
        end else if (w_field_chg || !w_edit) begin
            r_phase_cnt <= PH_ZERO;
            r_blink_on  <= 1'b1;
            r_hold_cnt  <= HOLD_ZERO;
        end else if (bus.btn_adj) begin
            r_phase_cnt <= PH_ZERO;
            r_blink_on  <= 1'b1;
            r_hold_cnt  <= HOLD_LOAD;
        end else if (w_tick) begin
            if (r_hold_cnt != HOLD_ZERO) begin
                r_hold_cnt  <= r_hold_cnt - HOLD_ONE;
                r_phase_cnt <= r_phase_cnt;
                r_blink_on  <= r_blink_on;
            end else if (r_phase_cnt == PH_LAST) begin
                r_hold_cnt  <= r_hold_cnt;
                r_phase_cnt <= PH_ZERO;
                r_blink_on  <= !r_blink_on;
            end else begin
                r_hold_cnt  <= r_hold_cnt;
                r_phase_cnt <= r_phase_cnt + PH_ONE;
                r_blink_on  <= r_blink_on;
            end
        end else begin
            r_phase_cnt <= r_phase_cnt;
            r_blink_on  <= r_blink_on;
            r_hold_cnt  <= r_hold_cnt;
        end
    end

    // Output decode: blank the selected field in the off half when not held.
    always_comb begin
        w_blank       = r_editing && !r_blink_on && (r_hold_cnt == HOLD_ZERO);
        w_editing_nxt = (w_field_nxt != ST_RUN);
        if (w_blank) begin
            w_seg_nxt = blank_field(bus.seg_in, r_field);
        end else begin
            w_seg_nxt = bus.seg_in;
        end
    end

    // Output registers: one clock of latency from seg_in and blink state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seg_out <= {6{SEG_OFF}};
            r_editing <= 1'b0;
        end else begin
            r_seg_out <= w_seg_nxt;
            r_editing <= w_editing_nxt;
        end
    end

    assign bus.seg_out = r_seg_out;
    assign bus.field   = r_field;
    assign bus.editing = r_editing;

endmodule

// File: tb/tb_flicker_field_blinker.sv
// Self-checking bench for flicker_field_blinker (PHASE=2, HOLD=3, TIMEOUT=8).
// The reference model counts ticks since the last field change or adjust
// press and derives the blank decision arithmetically from that count.
module tb_flicker_field_blinker;
    localparam int         P   = 2;
    localparam int         H   = 3;
    localparam int         T   = 8;
    localparam logic [6:0] OFF = 7'h7F;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    flicker_field_blinker_if bus();

    flicker_field_blinker #(
        .PHASE_TICKS(P), .HOLD_TICKS(H), .TIMEOUT_TICKS(T), .SEG_OFF(OFF)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // model state
    int          m_field;
    int          m_n;      // ticks since last restart event in edit
    int          m_hold;   // ticks forced visible after the restart event
    logic        m_prev;
    logic [41:0] m_seg;
    logic        flk = 1'b0;
    bit          rand_flk = 1'b0;
    int          cyc = 0;

    function automatic bit model_blank();
        return (m_field != 0) && (m_n >= m_hold) && ((((m_n - m_hold) / P) % 2) == 1);
    endfunction

    function automatic logic [41:0] rnd_seg();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[41:0];
    endfunction

    task automatic model_reset();
        m_field = 0; m_n = 0; m_hold = 0; m_prev = 1'b0; m_seg = {6{OFF}};
    endtask

    // Drive one clock of inputs and advance the reference model.
    task automatic step(input bit mode, input bit adj, input logic [41:0] seg);
        bit tick;
        int hi;
        bus.btn_mode = mode; bus.btn_adj = adj; bus.seg_in = seg;
        if (rand_flk) flk = 1'($urandom_range(0, 1));
        else if (cyc % 4 == 3) flk = ~flk;
        cyc++;
        bus.ClkFlick = flk;
        @(posedge clk);
        tick = (flk != m_prev);
        m_prev = flk;
        m_seg = seg;
        if (model_blank()) begin
            hi = 7 - 2 * m_field;
            for (int d = 0; d < 6; d++)
                if (d == hi || d == hi - 1) m_seg[7*d +: 7] = OFF;
        end
        if (mode) begin
            m_field = (m_field + 1) % 4; m_n = 0; m_hold = 0;
        end else if (m_field != 0 && adj) begin
            m_n = 0; m_hold = H;
        end else if (m_field != 0 && tick) begin
            m_n++;
`ifdef AUTO_TIMEOUT_EN
            if (m_n == T) begin m_field = 0; m_n = 0; m_hold = 0; end
`endif
        end else if (m_field == 0) begin
            m_n = 0; m_hold = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.btn_mode = 1'b0; bus.btn_adj = 1'b0; bus.seg_in = '0;
        flk = 1'b0; bus.ClkFlick = 1'b0; cyc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.btn_mode = 1'b0; bus.btn_adj = 1'b0; bus.seg_in = '0;
        flk = 1'b0; bus.ClkFlick = 1'b0; cyc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.seg_out !== {6{OFF}}) begin n_err++; $display("FAIL reset_seg: got %h want %h", bus.seg_out, {6{OFF}}); end
        n_cmp++; if (bus.field !== 2'd0) begin n_err++; $display("FAIL reset_field: got %0d want 0", bus.field); end
        n_cmp++; if (bus.editing !== 1'b0) begin n_err++; $display("FAIL reset_editing: got %b want 0", bus.editing); end
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.seg_out !== {6{OFF}}) begin n_err++; $display("FAIL release_seg: got %h want %h", bus.seg_out, {6{OFF}}); end
        step(1'b0, 1'b0, 42'h0);
        n_cmp++; if (bus.seg_out !== 42'h0) begin n_err++; $display("FAIL first_seg: got %h want 0", bus.seg_out); end
        n_cmp++; if (bus.field !== 2'd0 || bus.editing !== 1'b0) begin n_err++; $display("FAIL first_state: field %0d editing %b want 0 0", bus.field, bus.editing); end
    endtask

    task automatic test_blink();
        int n_blank = 0;
        int n_vis = 0;
        step(1'b1, 1'b0, 42'h0);
        n_cmp++; if (bus.field !== 2'd1 || bus.editing !== 1'b1) begin n_err++; $display("FAIL enter_hr: field %0d editing %b want 1 1", bus.field, bus.editing); end
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, 42'h0);
            n_cmp++; if (bus.seg_out !== m_seg || bus.field !== 2'(m_field)) begin n_err++; $display("FAIL blink c%0d: seg %h want %h field %0d want %0d", i, bus.seg_out, m_seg, bus.field, m_field); end
            n_cmp++; if (bus.seg_out[27:0] !== 28'h0) begin n_err++; $display("FAIL blink_low c%0d: got %h want 0", i, bus.seg_out[27:0]); end
            if (bus.seg_out[41:28] === {OFF, OFF}) n_blank++;
            else n_vis++;
        end
        n_cmp++; if (n_blank == 0 || n_vis == 0) begin n_err++; $display("FAIL blink_both: blank %0d visible %0d want both nonzero", n_blank, n_vis); end
    endtask

    task automatic test_adjust();
        int guard = 0;
        while (!model_blank() && guard < 40) begin
            step(1'b0, 1'b0, rnd_seg());
            guard++;
        end
        n_cmp++; if (!model_blank()) begin n_err++; $display("FAIL adj_wait: no blank phase within %0d cycles", guard); end
        step(1'b0, 1'b1, rnd_seg());
        n_cmp++; if (bus.seg_out !== m_seg) begin n_err++; $display("FAIL adj_press: got %h want %h", bus.seg_out, m_seg); end
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, rnd_seg());
            n_cmp++; if (bus.seg_out !== m_seg || bus.field !== 2'(m_field)) begin n_err++; $display("FAIL adj c%0d: seg %h want %h field %0d want %0d", i, bus.seg_out, m_seg, bus.field, m_field); end
        end
    endtask

    task automatic test_mode_adj_same();
        logic [41:0] s;
        step(1'b1, 1'b1, rnd_seg());
        n_cmp++; if (bus.field !== 2'd2) begin n_err++; $display("FAIL mode_adj_field: got %0d want 2", bus.field); end
        s = rnd_seg();
        step(1'b0, 1'b0, s);
        n_cmp++; if (bus.seg_out[27:14] !== s[27:14]) begin n_err++; $display("FAIL min_visible: got %h want %h", bus.seg_out[27:14], s[27:14]); end
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'b0, rnd_seg());
            n_cmp++; if (bus.seg_out !== m_seg || bus.field !== 2'(m_field)) begin n_err++; $display("FAIL mode_adj c%0d: seg %h want %h field %0d want %0d", i, bus.seg_out, m_seg, bus.field, m_field); end
        end
    endtask

    task automatic test_mode_cycle();
        logic [41:0] prev;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b0, rnd_seg());
            n_cmp++; if (bus.field !== 2'(i % 4) || bus.seg_out !== m_seg) begin n_err++; $display("FAIL mode_seq %0d: field %0d want %0d seg %h want %h", i, bus.field, i % 4, bus.seg_out, m_seg); end
        end
        prev = rnd_seg();
        step(1'b0, 1'b0, prev);
        for (int i = 0; i < 10; i++) begin
            logic [41:0] s;
            s = rnd_seg();
            step(1'b0, 1'b1, s);
            n_cmp++; if (bus.seg_out !== s || bus.editing !== 1'b0) begin n_err++; $display("FAIL run_pass c%0d: seg %h want %h editing %b", i, bus.seg_out, s, bus.editing); end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 42'h0);
        n_cmp++; if (bus.field !== 2'd3) begin n_err++; $display("FAIL sec_entry: got %0d want 3", bus.field); end
        for (int i = 0; i < 90; i++) begin
            step(1'b0, 1'b0, rnd_seg());
            n_cmp++; if (bus.seg_out !== m_seg || bus.field !== 2'(m_field) || bus.editing !== (m_field != 0)) begin n_err++; $display("FAIL timeout c%0d: seg %h want %h field %0d want %0d", i, bus.seg_out, m_seg, bus.field, m_field); end
        end
`ifdef AUTO_TIMEOUT_EN
        n_cmp++; if (bus.field !== 2'd0) begin n_err++; $display("FAIL timeout_end: got %0d want 0", bus.field); end
`else
        n_cmp++; if (bus.field !== 2'd3) begin n_err++; $display("FAIL no_timeout_end: got %0d want 3", bus.field); end
`endif
    endtask

    task automatic test_reset_mid_edit();
        step(1'b1, 1'b0, rnd_seg());
        repeat (5) step(1'b0, 1'b0, rnd_seg());
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (bus.field !== 2'd0 || bus.editing !== 1'b0 || bus.seg_out !== {6{OFF}}) begin n_err++; $display("FAIL mid_reset: field %0d editing %b seg %h want 0 0 %h", bus.field, bus.editing, bus.seg_out, {6{OFF}}); end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_random();
        bit md, ad;
        rand_flk = 1'b1;
        for (int i = 0; i < 600; i++) begin
            md = ($urandom_range(0, 15) == 0);
            ad = ($urandom_range(0, 5) == 0);
            step(md, ad, rnd_seg());
            n_cmp++; if (bus.seg_out !== m_seg || bus.field !== 2'(m_field) || bus.editing !== (m_field != 0)) begin n_err++; $display("FAIL random c%0d: seg %h want %h field %0d want %0d", i, bus.seg_out, m_seg, bus.field, m_field); end
        end
        rand_flk = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_blink();
        test_adjust();
        test_mode_adj_same();
        test_mode_cycle();
        test_timeout();
        test_reset_mid_edit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
